// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 types and default widths for the slave-side write responder.
package axi4_globals_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    FIXED    = 2'b00,
    INCR     = 2'b01,
    WRAP     = 2'b10,
    RESERVED = 2'b11
  } awburst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } bresp_e;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } axi4_slave_wr_state_e;

endpackage

// File: rtl/axi4_slave_wr_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi4_slave_wr_addr_gen
  import axi4_globals_pkg::*;
#(
  parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [2:0]               size,
  input  logic [7:0]               len,
  input  awburst_e                 burst,
  output logic [ADDRESS_WIDTH-1:0] next_addr
);

  localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);

  logic [ADDRESS_WIDTH-1:0] bytes;
  logic [ADDRESS_WIDTH-1:0] span;
  logic [ADDRESS_WIDTH-1:0] lower;
  logic [ADDRESS_WIDTH-1:0] stepped;

  always_comb begin
    bytes     = ONE << size;
    span      = (ADDRESS_WIDTH'(len) + ONE) << size;
    lower     = addr & ~(span - ONE);
    stepped   = addr + bytes;
    next_addr = addr;
    case (burst)
      INCR:    next_addr = (addr & ~(bytes - ONE)) + bytes;
      WRAP:    next_addr = (stepped == lower + span) ? lower : stepped;
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write responder: one AW burst at a time into a local byte memory,
// one B response per burst, plus a combinational debug byte-read port.
module axi4_slave_write_responder
  import axi4_globals_pkg::*;
#(
  parameter int              ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
  parameter int              DATA_WIDTH    = axi4_globals_pkg::DATA_WIDTH,
  parameter longint unsigned MIN_ADDRESS   = 0,
  parameter int unsigned     MEM_BYTES     = 4096
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [15:0]               awid,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awlock,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [15:0]               bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ADDRESS_WIDTH-1:0]  dbg_addr,
  output logic [7:0]                dbg_rdata
);

  localparam int              STRB_W   = DATA_WIDTH / 8;
  localparam int              EW       = ADDRESS_WIDTH + 16;
  localparam int              IW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [EW-1:0]   ONE_E    = EW'(1);
  localparam logic [EW-1:0]   MIN_E    = EW'(MIN_ADDRESS);
  localparam logic [EW-1:0]   MAX_E    = EW'(MIN_ADDRESS + MEM_BYTES - 1);
  localparam logic [EW-1:0]   SIZE_E   = EW'(MEM_BYTES);
  localparam logic [2:0]      MAX_SIZE = 3'($clog2(STRB_W));

  logic [7:0] mem [MEM_BYTES];

  axi4_slave_wr_state_e state_q, state_d;
  logic                 awready_d, wready_d, bvalid_d;
  logic [15:0]          bid_d;
  logic [1:0]           bresp_d;

  logic [15:0]              id_q;
  logic [ADDRESS_WIDTH-1:0] addr_q, next_addr;
  logic [7:0]               len_q, beat_cnt_q;
  logic [2:0]               size_q;
  awburst_e                 burst_q;
  bresp_e                   err_q;
  logic                     wlast_err_q;

  logic aw_hs, w_hs, b_hs, last_beat, wlast_err_now;
  logic unused_awlock;

  assign unused_awlock = awlock;
  assign aw_hs         = awvalid & awready;
  assign w_hs          = wvalid & wready;
  assign b_hs          = bvalid & bready;
  assign last_beat     = (beat_cnt_q == len_q);
  assign wlast_err_now = wlast_err_q | (wlast != last_beat);

  // Address decode and burst legality, evaluated on the AW channel.
  awburst_e      aw_burst;
  bresp_e        aw_err;
  logic [EW-1:0] aw_start, aw_bytes, aw_last;
  logic [EW:0]   aw_off;

  always_comb begin
    aw_burst = awburst_e'(awburst);
    aw_start = EW'(awaddr);
    aw_bytes = ONE_E << awsize;
    aw_last  = (aw_start & ~(aw_bytes - ONE_E)) + ((EW'(awlen) + ONE_E) << awsize) - ONE_E;
    aw_off   = {1'b0, aw_start} - {1'b0, MIN_E};
    aw_err   = OKAY;
    if (aw_off[EW])
      aw_err = DECERR;
    else if (aw_burst == INCR && aw_last > MAX_E)
      aw_err = DECERR;
    else if ((aw_burst == FIXED || aw_burst == WRAP) && aw_start > MAX_E)
      aw_err = DECERR;
    else if (aw_burst == RESERVED || awsize > MAX_SIZE ||
             (aw_burst == WRAP && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15})))
      aw_err = SLVERR;
  end

  axi4_slave_wr_addr_gen #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // Outputs are registered from the next state, so they track state one-for-one.
  always_comb begin
    state_d = state_q;
    bid_d   = bid;
    bresp_d = bresp;
    case (state_q)
      IDLE: if (aw_hs) state_d = DATA;
      DATA: if (w_hs && last_beat) begin
        state_d = RESP;
        bid_d   = id_q;
        bresp_d = (err_q != OKAY) ? err_q : (wlast_err_now ? SLVERR : OKAY);
      end
      RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= '0;
    end else begin
      state_q <= state_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bid     <= bid_d;
      bresp   <= bresp_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (aw_hs) begin
      id_q        <= awid;
      addr_q      <= awaddr;
      len_q       <= awlen;
      size_q      <= awsize;
      burst_q     <= aw_burst;
      err_q       <= aw_err;
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else if (w_hs) begin
      addr_q      <= next_addr;
      beat_cnt_q  <= beat_cnt_q + 8'd1;
      wlast_err_q <= wlast_err_now;
    end
  end

  logic [EW-1:0] w_base;
  logic [EW:0]   lane_off [STRB_W];
  logic [IW-1:0] lane_idx [STRB_W];
  logic          lane_en  [STRB_W];

  always_comb begin
    w_base = EW'(addr_q) & ~EW'(STRB_W - 1);
    for (int unsigned i = 0; i < STRB_W; i++) begin
      lane_off[i] = {1'b0, w_base + EW'(i)} - {1'b0, MIN_E};
      lane_en[i]  = wstrb[i] && !lane_off[i][EW] && (lane_off[i][EW-1:0] < SIZE_E);
      lane_idx[i] = IW'(lane_off[i][EW-1:0]);
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs && err_q == OKAY) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (lane_en[i]) mem[lane_idx[i]] <= wdata[8*i +: 8];
      end
    end
  end

  logic [EW:0] dbg_off;

  always_comb begin
    dbg_off   = {1'b0, EW'(dbg_addr)} - {1'b0, MIN_E};
    dbg_rdata = '0;
    if (!dbg_off[EW] && dbg_off[EW-1:0] < SIZE_E) dbg_rdata = mem[IW'(dbg_off[EW-1:0])];
  end

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Directed plus randomized bursts against a byte-array reference of the write responder.
module tb_axi4_slave_write_responder;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SB   = DW / 8;
  localparam int MEMB = 4096;

  logic          aclk = 1'b0;
  logic          areset;
  logic [15:0]   awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awlock, awvalid, awready;
  logic [DW-1:0] wdata;
  logic [SB-1:0] wstrb;
  logic          wlast, wvalid, wready;
  logic [15:0]   bid;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_rdata;

  always #5 aclk = ~aclk;

  axi4_slave_write_responder #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .MIN_ADDRESS   (0),
    .MEM_BYTES     (MEMB)
  ) dut (
    .aclk (aclk), .areset (areset),
    .awid (awid), .awaddr (awaddr), .awlen (awlen), .awsize (awsize), .awburst (awburst),
    .awlock (awlock), .awvalid (awvalid), .awready (awready),
    .wdata (wdata), .wstrb (wstrb), .wlast (wlast), .wvalid (wvalid), .wready (wready),
    .bid (bid), .bresp (bresp), .bvalid (bvalid), .bready (bready),
    .dbg_addr (dbg_addr), .dbg_rdata (dbg_rdata)
  );

  logic [7:0]    model [MEMB];
  logic [DW-1:0] dat [256];
  logic [SB-1:0] stb [256];
  int            nerr = 0;
  int            nchk = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic peek(input longint unsigned a, output logic [7:0] v);
    dbg_addr = AW'(a);
    #1;
    v = dbg_rdata;
  endtask

  // Error decided from the AW fields alone.
  function automatic logic [1:0] aw_err(input longint unsigned addr, input int len,
                                        input int size, input int burst_t);
    longint unsigned bytes = 64'd1 << size;
    longint unsigned last  = (addr - addr % bytes) + (len + 1) * bytes - 1;
    if (burst_t == 1 && last > MEMB - 1) return 2'b11;
    if ((burst_t == 0 || burst_t == 2) && addr > MEMB - 1) return 2'b11;
    if (burst_t == 3 || bytes > SB) return 2'b10;
    if (burst_t == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
    return 2'b00;
  endfunction

  // Closed-form address of beat k.
  function automatic longint unsigned beat_addr(input longint unsigned addr, input int len,
                                                input int size, input int burst_t, input int k);
    longint unsigned bytes = 64'd1 << size;
    longint unsigned span  = (len + 1) * bytes;
    longint unsigned lower = addr - addr % span;
    case (burst_t)
      1:       return (k == 0) ? addr : (addr - addr % bytes) + k * bytes;
      2:       return lower + (addr - lower + k * bytes) % span;
      default: return addr;
    endcase
  endfunction

  task automatic burst(input string tag, input logic [15:0] id, input longint unsigned addr,
                       input int len, input int size, input int burst_t,
                       input int flip, input int stall, input bit gaps);
    logic [1:0]      err, exp;
    bit              wl_bad = 0;
    int              n;
    longint unsigned ba, base;
    err     = aw_err(addr, len, size, burst_t);
    awid    = id;
    awaddr  = AW'(addr);
    awlen   = 8'(len);
    awsize  = 3'(size);
    awburst = 2'(burst_t);
    awlock  = 1'($urandom);
    awvalid = 1'b1;
    n = 0;
    while (awready !== 1'b1 && n < 20) begin tick(); n++; end
    check({tag, "_awready"}, awready, 1'b1);
    tick();
    awvalid = 1'b0;
    check({tag, "_after_aw"}, {awready, wready, bvalid}, 3'b010);
    for (int k = 0; k <= len; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; tick(); end
      wdata  = dat[k];
      wstrb  = stb[k];
      wlast  = (k == len) ^ (k == flip);
      wl_bad = wl_bad | (k == flip);
      wvalid = 1'b1;
      n = 0;
      while (wready !== 1'b1 && n < 20) begin tick(); n++; end
      if (err == 2'b00) begin
        ba   = beat_addr(addr, len, size, burst_t, k);
        base = ba - ba % SB;
        for (int i = 0; i < SB; i++)
          if (stb[k][i] && base + i < MEMB) model[base + i] = dat[k][8*i +: 8];
      end
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    exp = (err != 2'b00) ? err : (wl_bad ? 2'b10 : 2'b00);
    check({tag, "_bvalid"}, bvalid, 1'b1);
    check({tag, "_bid"}, bid, id);
    check({tag, "_bresp"}, bresp, exp);
    for (int s = 0; s < stall; s++) begin
      check({tag, "_hold"}, {bvalid, bid, bresp, awready, wready}, {1'b1, id, exp, 1'b0, 1'b0});
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, "_done"}, {bvalid, awready}, 2'b01);
  endtask

  task automatic mem_sweep(input string tag);
    int              bad = 0;
    longint unsigned bad_a = 0;
    logic [7:0]      got = 0, want = 0;
    for (int a = 0; a < MEMB; a++) begin
      dbg_addr = AW'(a);
      #1;
      if (dbg_rdata !== model[a]) begin
        if (bad == 0) begin bad_a = a; got = dbg_rdata; want = model[a]; end
        bad++;
      end
    end
    nchk++;
    assert (bad == 0) else begin
      nerr++;
      $error("FAIL %s mem[0x%0h] observed=0x%0h expected=0x%0h (%0d bytes differ)",
             tag, bad_a, got, want, bad);
    end
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    int         len, size, bt, flip;
    longint unsigned addr;

    areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; wlast = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
    wdata = '0; wstrb = '0; dbg_addr = '0;
    tick(); tick();
    check("reset_outputs", {awready, wready, bvalid, bid, bresp}, '0);
    areset = 1'b0;
    tick();
    check("idle_ready", {awready, wready, bvalid}, 3'b100);

    // Fill the whole memory with known data using maximum-length bursts.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 256; k++) begin dat[k] = $urandom; stb[k] = '1; end
      burst("init", 16'(b + 1), b * 1024, 255, 2, 1, -1, 0, 1'b0);
    end
    mem_sweep("mem_init");
    peek(MEMB, v);          check("dbg_oor_top", v, 8'h00);
    peek(64'hFFFF_FFFF, v); check("dbg_oor_max", v, 8'h00);

    for (int k = 0; k < 4; k++) begin dat[k] = 32'hA0 + k; stb[k] = '1; end
    burst("incr", 16'h1234, 'h10, 3, 2, 1, -1, 0, 1'b0);
    peek('h10, v); check("incr_0x10", v, 8'hA0);
    peek('h1C, v); check("incr_0x1C", v, 8'hA3);
    peek('h11, v); check("incr_0x11", v, 8'h00);

    for (int k = 0; k < 4; k++) begin dat[k] = 32'hC0C0_C000 + k; stb[k] = '1; end
    burst("wrap4", 16'h0042, 'h38, 3, 2, 2, -1, 0, 1'b0);
    peek('h38, v); check("wrap_0x38", v, 8'h00);
    peek('h3C, v); check("wrap_0x3C", v, 8'h01);
    peek('h30, v); check("wrap_0x30", v, 8'h02);
    peek('h34, v); check("wrap_0x34", v, 8'h03);
    for (int k = 0; k < 3; k++) begin dat[k] = $urandom; stb[k] = '1; end
    burst("wrap3", 16'h0043, 'h38, 2, 2, 2, -1, 0, 1'b0);

    for (int k = 0; k < 2; k++) begin dat[k] = $urandom; stb[k] = '1; end
    burst("decerr", 16'h0DEC, MEMB - 4, 1, 2, 1, -1, 0, 1'b0);

    for (int k = 0; k < 3; k++) begin dat[k] = 32'h4433_2211; stb[k] = SB'(1 << k); end
    burst("fixed", 16'h0F1F, 'h100, 2, 2, 0, -1, 0, 1'b0);
    peek('h100, v); check("fixed_0x100", v, 8'h11);
    peek('h101, v); check("fixed_0x101", v, 8'h22);
    peek('h102, v); check("fixed_0x102", v, 8'h33);

    for (int k = 0; k < 4; k++) begin dat[k] = $urandom; stb[k] = '1; end
    burst("wlast_early", 16'h0A5A, 'h200, 3, 2, 1, 1, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin dat[k] = $urandom; stb[k] = '1; end
    burst("stall", 16'hBEEF, 'h300, 1, 2, 1, -1, 5, 1'b0);
    mem_sweep("mem_directed");

    // Abandon a burst mid-way: two beats land, no B response follows.
    awid = 16'h5A5A; awaddr = 'h400; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("rst_mid_in_data", wready, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wdata = $urandom; wstrb = '1; wlast = 1'b0; wvalid = 1'b1;
      for (int i = 0; i < SB; i++) model['h400 + 4 * k + i] = wdata[8*i +: 8];
      tick();
    end
    wvalid = 1'b0;
    areset = 1'b1;
    tick();
    check("rst_mid_outputs", {awready, wready, bvalid, bid, bresp}, '0);
    areset = 1'b0;
    tick();
    check("rst_mid_recover", {awready, wready, bvalid}, 3'b100);
    tick();
    check("rst_mid_no_b", bvalid, 1'b0);

    for (int t = 0; t < 40; t++) begin
      bt   = $urandom_range(0, 3);
      size = $urandom_range(0, 3);
      if (bt == 2) begin
        case ($urandom_range(0, 4))
          0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15; default: len = 2;
        endcase
      end else len = $urandom_range(0, 15);
      addr = ($urandom_range(0, 3) == 0) ? MEMB - $urandom_range(1, 64) : $urandom_range(0, MEMB + 200);
      addr = addr & ~((64'd1 << size) - 1);
      flip = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      for (int k = 0; k <= len; k++) begin dat[k] = $urandom; stb[k] = SB'($urandom); end
      burst("rand", 16'($urandom), addr, len, size, bt, flip, $urandom_range(0, 3), 1'b1);
    end
    mem_sweep("mem_random");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
